// File: rtl/digit_scan_pkg.sv
// Shared types and the digit-selection helper for the digit scan sequencer.
package digit_scan_pkg;

  localparam int NUM_DIGITS = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } scan_state_t;

  // Result of a mask search: chosen digit plus a flag set when every digit is masked.
  typedef struct packed {
    logic       none;
    logic [1:0] idx;
  } pick_t;

  // Cyclic search starting at 'start' for the first digit whose mask bit is 0.
  // Walking the offsets from high to low lets the smallest offset win.
  function automatic pick_t first_unmasked(input logic [NUM_DIGITS-1:0] mask,
                                           input logic [1:0]            start);
    pick_t      r;
    logic [1:0] cand;
    r.none = 1'b1;
    r.idx  = start;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      cand = start + 2'(k);
      if (!mask[cand]) begin
        r.none = 1'b0;
        r.idx  = cand;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/digit_scan_sequencer_pick.sv
// Combinational wrapper around first_unmasked; the top feeds it either
// digit 0 (leaving IDLE) or the digit after the current one (advancing).
module digit_pick
  import digit_scan_pkg::*;
(
  input  logic [NUM_DIGITS-1:0] mask_i,
  input  logic [1:0]            start_i,
  output logic [1:0]            idx_o,
  output logic                  none_o
);

  pick_t pick_d;

  assign pick_d = first_unmasked(mask_i, start_i);
  assign idx_o  = pick_d.idx;
  assign none_o = pick_d.none;

endmodule

// File: rtl/digit_scan_sequencer.sv
// Scans four display digits through a 2-to-4 decoder: each digit gets a
// blanking interval (decoder disabled) and then an on interval. The select
// lines only move while the decoder is disabled, which avoids ghosting.
module digit_scan_sequencer
  import digit_scan_pkg::*;
#(
  parameter int BLANK_CYCLES = 2,
  parameter int SHOW_CYCLES  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run,
  input  logic [NUM_DIGITS-1:0] digit_mask,
  output logic [1:0]            ip,
  output logic                  Enable,
  output logic                  tick,
  output logic                  frame_done
);

  localparam int MAX_CYCLES = (BLANK_CYCLES > SHOW_CYCLES) ? BLANK_CYCLES : SHOW_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] BLANK_LOAD = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] SHOW_LOAD  = CW'(SHOW_CYCLES - 1);

  scan_state_t   state_q;
  logic [1:0]    idx_q;
  logic [CW-1:0] cnt_q;
  // Set while parked in BLANK because every digit was masked at an advance.
  logic          wait_q;
  logic [1:0]    ip_q;
  logic          enable_q;
  logic          tick_q;
  logic          frame_done_q;

  logic [1:0]    pick_start_d;
  logic [1:0]    pick_idx_d;
  logic          pick_none_d;

  // Leaving IDLE always restarts from the lowest unmasked digit; otherwise
  // search from the digit after the current one so the current digit comes last.
  assign pick_start_d = (state_q == IDLE) ? 2'd0 : (idx_q + 2'd1);

  digit_pick u_pick (
    .mask_i  (digit_mask),
    .start_i (pick_start_d),
    .idx_o   (pick_idx_d),
    .none_o  (pick_none_d)
  );

  // Scan FSM with registered outputs; run=0 overrides every state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      idx_q        <= 2'd0;
      cnt_q        <= '0;
      wait_q       <= 1'b0;
      ip_q         <= 2'b11;
      enable_q     <= 1'b1;
      tick_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      tick_q       <= 1'b0;
      frame_done_q <= 1'b0;
      if (!run) begin
        // idx is kept, but a restart re-chooses it from the mask anyway.
        state_q  <= IDLE;
        enable_q <= 1'b1;
        wait_q   <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            enable_q <= 1'b1;
            if (!pick_none_d) begin
              idx_q   <= pick_idx_d;
              ip_q    <= ~pick_idx_d;
              cnt_q   <= BLANK_LOAD;
              state_q <= BLANK;
            end
          end
          BLANK: begin
            if (wait_q) begin
              // A deferred advance completes as soon as any digit is unmasked,
              // followed by a full blanking interval on the new digit.
              if (!pick_none_d) begin
                idx_q        <= pick_idx_d;
                ip_q         <= ~pick_idx_d;
                cnt_q        <= BLANK_LOAD;
                wait_q       <= 1'b0;
                tick_q       <= 1'b1;
                frame_done_q <= (pick_idx_d <= idx_q);
              end
            end else if (cnt_q == '0) begin
              state_q  <= SHOW;
              cnt_q    <= SHOW_LOAD;
              enable_q <= 1'b0;
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
          SHOW: begin
            if (cnt_q == '0) begin
              state_q  <= BLANK;
              enable_q <= 1'b1;
              cnt_q    <= BLANK_LOAD;
              if (pick_none_d) begin
                wait_q <= 1'b1;
              end else begin
                idx_q        <= pick_idx_d;
                ip_q         <= ~pick_idx_d;
                tick_q       <= 1'b1;
                frame_done_q <= (pick_idx_d <= idx_q);
              end
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
          default: begin
            state_q  <= IDLE;
            enable_q <= 1'b1;
          end
        endcase
      end
    end
  end

  assign ip         = ip_q;
  assign Enable     = enable_q;
  assign tick       = tick_q;
  assign frame_done = frame_done_q;

endmodule

// File: doc/digit_scan_sequencer.md
# digit_scan_sequencer

Drives the 2-to-4 decoder's select (`ip`) and active-low `Enable` inputs so its four one-hot outputs light four display digits in turn. Each digit gets a programmable blanking interval followed by a programmable on interval. The block sits directly upstream of the decoder. It is the only sequential stage in the digit-select path.

## Interface
- `BLANK_CYCLES`, default 2: cycles the decoder is disabled before each digit is shown. Minimum 1.
- `SHOW_CYCLES`, default 8: cycles each digit is shown with the decoder enabled. Minimum 1.
- `clk`  in  1: single clock. All state updates on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `run`  in  1: level. 1 = scan; 0 = stop and blank.
- `digit_mask`  in  4: bit n = 1 skips digit n.
- `ip`  out  2: decoder select. Driven as the bitwise inverse of the digit index, so decoder output `op[n]` corresponds to digit n.
- `Enable`  out  1: decoder enable, active-low. 1 = all decoder outputs off.
- `tick`  out  1: one-cycle pulse on each digit advance.
- `frame_done`  out  1: one-cycle pulse when the digit index wraps.

## Operation
- States: IDLE, BLANK, SHOW. The 2-bit digit index is `idx`; the down-counter is `cnt`.
- Reset (async, takes effect immediately):
  - state = IDLE, `idx` = 0
  - `ip` = 2'b11, `Enable` = 1
  - `tick` = 0, `frame_done` = 0
- IDLE:
  - Outputs: `Enable` = 1.
  - Exit: on `run` = 1 with at least one unmasked digit:
    - `idx` = lowest unmasked digit
    - go to BLANK, `cnt` = BLANK_CYCLES-1
  - If all digits are masked: stay in IDLE.
- BLANK:
  - Outputs: `Enable` = 1, `ip` = ~`idx`.
  - Decrement `cnt`. At `cnt` = 0: go to SHOW, `cnt` = SHOW_CYCLES-1.
- SHOW:
  - Outputs: `Enable` = 0, `ip` = ~`idx`.
  - Decrement `cnt`. At `cnt` = 0, advance:
    - `idx` = next unmasked digit after `idx` in cyclic order 0→1→2→3→0. If `idx` is the only unmasked digit, it stays the same.
    - go to BLANK, `cnt` reloaded to BLANK_CYCLES-1.
    - `tick` = 1 for one cycle.
    - `frame_done` = 1 for the same cycle if new `idx` ≤ old `idx`.
- `digit_mask` is sampled only when choosing a digit (IDLE exit or advance). Masking the digit currently shown does not cut its SHOW short.
- All digits masked at an advance:
  - Stay in BLANK with `cnt` reloaded; no `tick`.
  - Re-check the mask every cycle. On the first unmasked digit, pick the next unmasked digit after `idx`, then do a full BLANK.
- `run` = 0 in any state: the next state is IDLE and `Enable` = 1. `idx` is held but re-chosen on restart.
- `ip` changes only on entry to BLANK, never while `Enable` = 0. This is what prevents ghosting.

## Timing
- All outputs are registered; none is combinational from an input.
- Digit period = BLANK_CYCLES + SHOW_CYCLES. With defaults: 10 cycles, 40-cycle frame.
- Start-up: `run` rises before edge E0. First BLANK cycle follows E0; first `Enable` = 0 follows edge E0+BLANK_CYCLES.
- `tick` and `frame_done` are asserted during the first BLANK cycle of the new digit.
- Stop latency: one edge from `run` = 0 to `Enable` = 1.
- Reset mid-SHOW: `Enable` goes to 1 asynchronously. No `tick` pulse after reset is released.
- Counter width = $clog2(max(BLANK_CYCLES, SHOW_CYCLES)+1).

## Structure
- Package `digit_scan_pkg` holds:
  - `scan_state_t` enum {IDLE, BLANK, SHOW}
  - localparam `NUM_DIGITS` = 4
  - function `first_unmasked(mask, start)` returning the index plus a none-found flag.
- One combinational sub-module, `digit_pick`, wraps `first_unmasked` for the IDLE-exit and advance paths.
- The 2-to-4 decoder is instantiated by the parent, not inside this block.

## Test plan
1. **Reset value:** `rst` pulse mid-SHOW → outputs immediately `Enable` = 1, `ip` = 2'b11, `tick` = 0, `frame_done` = 0; state IDLE after release.
2. **Full frame with defaults, mask 4'b0000, `run` = 1:**
   - `ip` goes 11, 10, 01, 00.
   - Each digit has 2 cycles `Enable` = 1, then 8 cycles `Enable` = 0.
   - `tick` every 10 cycles; `frame_done` every 40 cycles.
   - `ip` never changes while `Enable` = 0.
3. **Mask 4'b1010:** only digits 0 and 2 are shown (`ip` 11, 01). `frame_done` every 20 cycles.
4. **Mask 4'b0111:**
   - digit 3 only, `ip` = 00
   - `tick` and `frame_done` together every 10 cycles
   - all bits set during SHOW → current SHOW completes, then `Enable` stays 1 with no `tick` until a mask bit clears.
5. **Stop mid-SHOW:** `run` = 0 at cycle 5 of SHOW → `Enable` = 1 on the next edge, state IDLE. `run` = 1 again → BLANK on lowest unmasked digit.
